// File: rtl/scanout_pkg.sv
// Shared timing constants and the per-pixel sync/window bundle
// carried down the fb_scanout_engine delay pipe.
package scanout_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   function automatic int h_total(input int act, input int fp,
                                  input int sy, input int bp);
      return act + fp + sy + bp;
   endfunction

   function automatic int v_total(input int act, input int fp,
                                  input int sy, input int bp);
      return act + fp + sy + bp;
   endfunction

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic in_win;
   } sync_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters plus stage-0 sync, active and
// framebuffer-window flags; frame_start marks counter position (0,0).
module vga_timing_gen
   import scanout_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int FB_W     = 256,
   parameter int FB_H     = 256,
   parameter int X_OFF    = 192,
   parameter int Y_OFF    = 112
) (
   input  logic  vga_clk,
   input  logic  reset,
   input  logic  enable,
   output sync_t sync,
   output logic  last,
   output logic  frame_start
);

   localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW = $clog2(HT);
   localparam int VW = $clog2(VT);

   localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_B   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_E   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] WX_B   = HW'(X_OFF);
   localparam logic [HW-1:0] WX_E   = HW'(X_OFF + FB_W);
   localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_B   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_E   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] WY_B   = VW'(Y_OFF);
   localparam logic [VW-1:0] WY_E   = VW'(Y_OFF + FB_H);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          fs_q;
   logic          h_end;
   logic          v_end;
   logic          hs;
   logic          vs;
   logic          act;
   logic          win;

   assign h_end = (h_cnt == H_LAST);
   assign v_end = (v_cnt == V_LAST);

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
         fs_q  <= 1'b0;
      end else if (enable) begin
         fs_q <= h_end & v_end;
         if (h_end) begin
            h_cnt <= '0;
            v_cnt <= v_end ? '0 : v_cnt + VW'(1);
         end else begin
            h_cnt <= h_cnt + HW'(1);
         end
      end
   end

   assign hs  = (h_cnt >= HS_B) && (h_cnt < HS_E);
   assign vs  = (v_cnt >= VS_B) && (v_cnt < VS_E);
   assign act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign win = (h_cnt >= WX_B) && (h_cnt < WX_E) &&
                (v_cnt >= WY_B) && (v_cnt < WY_E);

   assign sync        = {hs, vs, act, win};
   assign last        = h_end & v_end;
   // registered at the wrap so a reset-forced (0,0) never pulses
   assign frame_start = fs_q & enable;

endmodule

// File: rtl/fb_scanout_engine.sv
// VGA scan-out: timing, framebuffer addressing, RAM-latency realignment.
// Define SCANOUT_DBUF_EN for double-buffered frames (swap_req/buf_sel/swap_ack).
module fb_scanout_engine
   import scanout_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int FB_W     = 256,
   parameter int FB_H     = 256,
   parameter int X_OFF    = 192,
   parameter int Y_OFF    = 112,
   parameter int ADDR_W   = 16,
   parameter int PIX_W    = 32,
   parameter int RD_LAT   = 1,
   parameter bit SYNC_POL = 1'b0,
   parameter logic [PIX_W-1:0] BORDER_COLOR = '0
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic              enable,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   input  logic [PIX_W-1:0]  rd_data,
   output logic [PIX_W-1:0]  pixel,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic              frame_start
`ifdef SCANOUT_DBUF_EN
   ,
   input  logic              swap_req,
   output logic              buf_sel,
   output logic              swap_ack
`endif
);

   localparam int FB_SZ = FB_W * FB_H;
   localparam int DL    = RD_LAT + 1;

   if (X_OFF + FB_W > H_ACTIVE) begin : g_bad_x
      $error("framebuffer window exceeds H_ACTIVE");
   end
   if (Y_OFF + FB_H > V_ACTIVE) begin : g_bad_y
      $error("framebuffer window exceeds V_ACTIVE");
   end
   if (FB_SZ > (1 << ADDR_W)) begin : g_bad_sz
      $error("framebuffer does not fit ADDR_W");
   end
   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("RD_LAT must be 1..4");
   end

   sync_t             s0;
   logic              last;
   logic [ADDR_W-1:0] addr_cnt;
   logic [ADDR_W-1:0] base_next;
   sync_t             pipe [1:DL];

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .FB_W (FB_W), .FB_H (FB_H), .X_OFF (X_OFF), .Y_OFF (Y_OFF)
   ) u_timing (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .enable      (enable),
      .sync        (s0),
      .last        (last),
      .frame_start (frame_start)
   );

`ifdef SCANOUT_DBUF_EN
   logic pending;
   logic swap_now;

   if (2 * FB_SZ > (1 << ADDR_W)) begin : g_bad_dbuf
      $error("two framebuffers do not fit ADDR_W");
   end

   assign swap_now = last & (pending | swap_req);
   assign swap_ack = enable & ~reset & swap_now;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         buf_sel <= 1'b0;
         pending <= 1'b0;
      end else if (enable) begin
         if (swap_now) begin
            buf_sel <= ~buf_sel;
            pending <= 1'b0;
         end else if (swap_req) begin
            pending <= 1'b1;
         end
      end
   end

   // base of the frame about to start, so the swap lands on its first pixel
   assign base_next = (buf_sel ^ swap_now) ? ADDR_W'(FB_SZ) : '0;
`else
   assign base_next = '0;
`endif

   assign rd_en = enable;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         addr_cnt <= '0;
         rd_addr  <= '0;
      end else if (enable) begin
         rd_addr <= addr_cnt;
         if (last) begin
            addr_cnt <= base_next;
         end else if (s0.in_win) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         for (int i = 1; i <= DL; i++) begin
            pipe[i] <= '0;
         end
      end else if (enable) begin
         pipe[1] <= s0;
         for (int i = 2; i <= DL; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         pixel <= '0;
         de    <= 1'b0;
         hsync <= ~SYNC_POL;
         vsync <= ~SYNC_POL;
      end else if (enable) begin
         if (pipe[DL].in_win) begin
            pixel <= rd_data;
         end else begin
            pixel <= pipe[DL].de ? BORDER_COLOR : '0;
         end
         de    <= pipe[DL].de;
         hsync <= pipe[DL].hs ~^ SYNC_POL;
         vsync <= pipe[DL].vs ~^ SYNC_POL;
      end
   end

endmodule

// File: tb/tb_fb_scanout_engine.sv
// Self-checking bench for fb_scanout_engine on a shrunken raster,
// compared against an arithmetic model of frame position and address.
module tb_fb_scanout_engine;

   localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
   localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FT = HT * VT;
   localparam int FBW = 16, FBH = 16, XO = 12, YO = 7;
   localparam int RD_LAT = 2;
   localparam int D = RD_LAT + 2;
`ifdef SCANOUT_DBUF_EN
   localparam int AW = 9;
`else
   localparam int AW = 8;
`endif
   localparam logic [31:0] BORDER = 32'hB0DE_0001;

   logic          vga_clk;
   logic          reset;
   logic          enable;
   logic          swap_req;
   logic [AW-1:0] rd_addr;
   logic          rd_en;
   logic [31:0]   rd_data;
   logic [31:0]   pixel;
   logic          hsync, vsync, de, frame_start;
   logic          buf_sel, swap_ack;

   fb_scanout_engine #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
      .FB_W (FBW), .FB_H (FBH), .X_OFF (XO), .Y_OFF (YO),
      .ADDR_W (AW), .PIX_W (32), .RD_LAT (RD_LAT),
      .SYNC_POL (1'b0), .BORDER_COLOR (BORDER)
   ) dut (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .enable      (enable),
      .rd_addr     (rd_addr),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .pixel       (pixel),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .frame_start (frame_start)
`ifdef SCANOUT_DBUF_EN
      ,
      .swap_req    (swap_req),
      .buf_sel     (buf_sel),
      .swap_ack    (swap_ack)
`endif
   );

`ifndef SCANOUT_DBUF_EN
   assign buf_sel  = 1'b0;
   assign swap_ack = 1'b0;
`endif

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   // RAM with q = address, RD_LAT enabled cycles deep
   logic [31:0] qp [RD_LAT];
   always @(posedge vga_clk) begin
      if (rd_en) begin
         qp[0] <= 32'(rd_addr);
         for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
      end
   end
   assign rd_data = qp[RD_LAT-1];

   int checks = 0;
   int errors = 0;
   int pos = 0;
   bit pend = 0;
   bit bsel = 0;
   int fbase [int];

   logic [AW-1:0] e_addr;
   logic [31:0]   e_pix;
   logic          e_de, e_hs, e_vs, e_fs, e_ack, e_sel;

   function automatic int addr_at(input int p);
      int f, q, v, h, cnt;
      f = p / FT;
      q = p % FT;
      v = q / HT;
      h = q % HT;
      if (v < YO) cnt = 0;
      else if (v >= YO + FBH) cnt = FBW * FBH;
      else cnt = FBW * (v - YO);
      if (v >= YO && v < YO + FBH) begin
         if (h >= XO + FBW) cnt += FBW;
         else if (h >= XO) cnt += h - XO;
      end
      return (fbase[f] + cnt) % (1 << AW);
   endfunction

   task automatic drive(input logic en, input logic rst, input logic sw);
      int c, h, v;
      bit act, win;
      enable   = en;
      reset    = rst;
      swap_req = sw;
      #1;
      e_addr = (pos >= 1) ? AW'(addr_at(pos - 1)) : '0;
      if (pos >= D) begin
         c   = pos - D;
         h   = (c % FT) % HT;
         v   = (c % FT) / HT;
         act = (h < HA) && (v < VA);
         win = (h >= XO) && (h < XO + FBW) && (v >= YO) && (v < YO + FBH);
         e_de  = act;
         e_pix = win ? 32'(addr_at(c)) : (act ? BORDER : 32'h0);
         e_hs  = !((h >= HA + HFP) && (h < HA + HFP + HSY));
         e_vs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
      end else begin
         e_de  = 1'b0;
         e_pix = '0;
         e_hs  = 1'b1;
         e_vs  = 1'b1;
      end
      e_fs  = en && (pos > 0) && (pos % FT == 0);
      e_ack = en && !rst && (pos % FT == FT - 1) && (pend || sw);
      e_sel = bsel;
   endtask

   task automatic tick();
      @(posedge vga_clk);
      if (reset) begin
         pos  = 0;
         pend = 0;
         bsel = 0;
         fbase.delete();
         fbase[0] = 0;
      end else if (enable) begin
         if (pos % FT == FT - 1) begin
            if (pend || swap_req) begin
               bsel = !bsel;
               pend = 0;
            end
            fbase[pos / FT + 1] = bsel ? FBW * FBH : 0;
         end else if (swap_req) begin
            pend = 1;
         end
         pos++;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0);
         tick();
      end
      for (int i = 0; i < D + 3; i++) begin
         drive(1, 0, 0);
         checks += 5;
         if (hsync !== e_hs || vsync !== e_vs) begin
            errors++;
            $display("FAIL reset_sync i=%0d got %b%b exp %b%b",
                     i, hsync, vsync, e_hs, e_vs);
         end
         if (de !== e_de) begin
            errors++;
            $display("FAIL reset_de i=%0d got %b exp %b", i, de, e_de);
         end
         if (pixel !== e_pix) begin
            errors++;
            $display("FAIL reset_pix i=%0d got %h exp %h", i, pixel, e_pix);
         end
         if (rd_addr !== e_addr) begin
            errors++;
            $display("FAIL reset_addr i=%0d got %0d exp %0d", i, rd_addr, e_addr);
         end
         if (de !== (i >= D)) begin
            errors++;
            $display("FAIL first_de i=%0d got %b exp %b", i, de, i >= D);
         end
         tick();
      end
   endtask

   task automatic test_timing();
      int fs_n = 0;
      for (int i = 0; i < 2 * FT; i++) begin
         drive(1, 0, 0);
         checks += 3;
         if (hsync !== e_hs) begin
            errors++;
            $display("FAIL hsync pos=%0d got %b exp %b", pos, hsync, e_hs);
         end
         if (vsync !== e_vs) begin
            errors++;
            $display("FAIL vsync pos=%0d got %b exp %b", pos, vsync, e_vs);
         end
         if (frame_start !== e_fs) begin
            errors++;
            $display("FAIL frame_start pos=%0d got %b exp %b", pos, frame_start, e_fs);
         end
         if (frame_start === 1'b1) fs_n++;
         tick();
      end
      checks++;
      if (fs_n != 2) begin
         errors++;
         $display("FAIL fs_count got %0d exp 2", fs_n);
      end
   endtask

   task automatic test_window();
      for (int i = 0; i < FT; i++) begin
         drive(1, 0, 0);
         checks += 3;
         if (rd_addr !== e_addr) begin
            errors++;
            $display("FAIL win_addr pos=%0d got %0d exp %0d", pos, rd_addr, e_addr);
         end
         if (pixel !== e_pix) begin
            errors++;
            $display("FAIL win_pix pos=%0d got %h exp %h", pos, pixel, e_pix);
         end
         if (de !== e_de) begin
            errors++;
            $display("FAIL win_de pos=%0d got %b exp %b", pos, de, e_de);
         end
         tick();
      end
   endtask

   task automatic test_enable();
      bit en;
      int hold = 0;
      bit held = 0;
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 3) != 0);
         if (!held && (pos % HT == 30)) begin
            hold = 5;
            held = 1;
         end
         if (hold > 0) begin
            en = 0;
            hold--;
         end
         drive(en, 0, 0);
         checks += 5;
         if (rd_en !== en) begin
            errors++;
            $display("FAIL rd_en i=%0d got %b exp %b", i, rd_en, en);
         end
         if (pixel !== e_pix || de !== e_de) begin
            errors++;
            $display("FAIL en_pix pos=%0d got %h/%b exp %h/%b",
                     pos, pixel, de, e_pix, e_de);
         end
         if (hsync !== e_hs || vsync !== e_vs) begin
            errors++;
            $display("FAIL en_sync pos=%0d got %b%b exp %b%b",
                     pos, hsync, vsync, e_hs, e_vs);
         end
         if (rd_addr !== e_addr) begin
            errors++;
            $display("FAIL en_addr pos=%0d got %0d exp %0d", pos, rd_addr, e_addr);
         end
         if (frame_start !== e_fs) begin
            errors++;
            $display("FAIL en_fs pos=%0d got %b exp %b", pos, frame_start, e_fs);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int fs_at = -1;
      while ((pos % FT) != 20 * HT + 30 && n < 2 * FT) begin
         drive(1, 0, 0);
         tick();
         n++;
      end
      checks++;
      if (n >= 2 * FT) begin
         errors++;
         $display("FAIL mid_seek timeout after %0d cycles", n);
      end
      drive(1, 1, 0);
      tick();
      drive(1, 0, 0);
      checks += 2;
      if (de !== 1'b0 || rd_addr !== '0) begin
         errors++;
         $display("FAIL mid_reset got de=%b addr=%0d exp de=0 addr=0", de, rd_addr);
      end
      if (hsync !== 1'b1 || vsync !== 1'b1 || pixel !== '0) begin
         errors++;
         $display("FAIL mid_reset_out got %b%b %h exp 11 0", hsync, vsync, pixel);
      end
      for (int i = 0; i < FT + D; i++) begin
         checks++;
         if (frame_start !== e_fs) begin
            errors++;
            $display("FAIL mid_fs pos=%0d got %b exp %b", pos, frame_start, e_fs);
         end
         if (frame_start === 1'b1 && fs_at < 0) fs_at = pos;
         tick();
         drive(1, 0, 0);
      end
      checks++;
      if (fs_at != FT) begin
         errors++;
         $display("FAIL mid_fs_at got %0d exp %0d", fs_at, FT);
      end
   endtask

`ifdef SCANOUT_DBUF_EN
   task automatic test_dbuf();
      int n = 0;
      bit seen = 0;
      while ((pos % FT) != 10 * HT && n < 2 * FT) begin
         drive(1, 0, 0);
         tick();
         n++;
      end
      drive(1, 0, 1);
      tick();
      for (int i = 0; i < FT + 4 && !seen; i++) begin
         drive(1, 0, 0);
         checks += 2;
         if (buf_sel !== e_sel) begin
            errors++;
            $display("FAIL buf_sel pos=%0d got %b exp %b", pos, buf_sel, e_sel);
         end
         if (swap_ack !== e_ack) begin
            errors++;
            $display("FAIL swap_ack pos=%0d got %b exp %b", pos, swap_ack, e_ack);
         end
         if (pos % FT == 1) begin
            seen = 1;
            checks += 2;
            if (rd_addr !== AW'(FBW * FBH)) begin
               errors++;
               $display("FAIL dbuf_addr got %0d exp %0d", rd_addr, FBW * FBH);
            end
            if (buf_sel !== 1'b1) begin
               errors++;
               $display("FAIL dbuf_sel got %b exp 1", buf_sel);
            end
         end
         tick();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL dbuf_timeout frame end not reached");
      end
   endtask
`endif

   initial begin
      enable   = 1'b0;
      reset    = 1'b1;
      swap_req = 1'b0;
      fbase[0] = 0;
      test_reset();
      test_timing();
      test_window();
      test_enable();
      test_reset_mid();
`ifdef SCANOUT_DBUF_EN
      test_dbuf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
